// File: rtl/rx_dispatch_ctrl_if.sv
// Handshake bundle for rx_dispatch_ctrl: MAC-side word stream plus the
// receive-buffer data/type/ack port. "master" is the controller side,
// "slave" is the surrounding MAC and buffer.
interface rx_dispatch_ctrl_if;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_ready;
  logic [31:0] buf_data;
  logic [1:0]  buf_type;
  logic        buf_ack;

  modport master (
    input  rx_data, rx_valid, rx_sof, rx_eof, buf_ack,
    output rx_ready, buf_data, buf_type
  );

  modport slave (
    output rx_data, rx_valid, rx_sof, rx_eof, buf_ack,
    input  rx_ready, buf_data, buf_type
  );
endinterface

// File: rtl/rx_dispatch_ctrl.sv
// Receive dispatch controller: collects a 4-word Ethernet header,
// classifies it by EtherType (word 3, bits 31:16), then replays the
// header and forwards the payload word by word to the receive buffer
// through a four-phase data/type/ack handshake. Other frame types and
// runts are dropped.
// Optional frame counters are built when RX_DISPATCH_STATS_EN is defined;
// otherwise arp_cnt/ip_cnt/drop_cnt are tied to zero.
module rx_dispatch_ctrl #(
  parameter logic [15:0] ETH_ARP = 16'h0806,
  parameter logic [15:0] ETH_IP  = 16'h0800
) (
  input  logic                clk,
  input  logic                reset,
  rx_dispatch_ctrl_if.master  bus,
  output logic                busy,
  output logic [15:0]         arp_cnt,
  output logic [15:0]         ip_cnt,
  output logic [15:0]         drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CLASS, S_SEND, S_RELEASE, S_FETCH, S_DROP
  } state_t;

  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_ARP  = 2'd1,
    T_IP   = 2'd2
  } ftype_t;

  state_t      state;
  ftype_t      ftype;
  ftype_t      buf_type_r;
  logic [31:0] buf_data_r;
  logic [31:0] hdr [4];
  logic [1:0]  hdr_cnt;
  logic [2:0]  replay;
  logic        last;

  logic        rx_open;
  logic        accept;
  logic        is_arp;
  logic        is_ip;

  // Word-accepting states; rx_ready is this decode gated by reset
  always_comb begin
    rx_open = 1'b0;
    case (state)
      S_IDLE, S_HDR, S_FETCH, S_DROP: rx_open = 1'b1;
      default:                        rx_open = 1'b0;
    endcase
  end

  assign accept       = bus.rx_valid & rx_open;
  assign bus.rx_ready = rx_open & ~reset;
  assign busy         = (state != S_IDLE) & ~reset;
  assign is_arp       = (hdr[3][31:16] == ETH_ARP);
  assign is_ip        = (hdr[3][31:16] == ETH_IP);
  assign bus.buf_data = buf_data_r;
  assign bus.buf_type = buf_type_r;

  // Main sequencer: header collection, classification, replay and forwarding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ftype      <= T_NONE;
      buf_type_r <= T_NONE;
      buf_data_r <= '0;
      hdr_cnt    <= '0;
      replay     <= '0;
      last       <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) hdr[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && bus.rx_sof) begin
            hdr[0]  <= bus.rx_data;
            hdr_cnt <= 2'd1;
            // a single-word frame is a runt and never leaves IDLE
            if (!bus.rx_eof) state <= S_HDR;
          end
        end
        S_HDR: begin
          if (accept) begin
            if (bus.rx_sof) begin
              hdr[0]  <= bus.rx_data;
              hdr_cnt <= 2'd1;
              if (bus.rx_eof) state <= S_IDLE;
            end else begin
              hdr[hdr_cnt] <= bus.rx_data;
              if (hdr_cnt == 2'd3) begin
                last  <= bus.rx_eof;
                state <= S_CLASS;
              end else if (bus.rx_eof) begin
                state <= S_IDLE;
              end else begin
                hdr_cnt <= hdr_cnt + 2'd1;
              end
            end
          end
        end
        S_CLASS: begin
          if (is_arp || is_ip) begin
            ftype      <= is_arp ? T_ARP : T_IP;
            buf_type_r <= is_arp ? T_ARP : T_IP;
            buf_data_r <= hdr[0];
            replay     <= 3'd1;
            state      <= S_SEND;
          end else begin
            state <= last ? S_IDLE : S_DROP;
          end
        end
        S_SEND: begin
          if (bus.buf_ack) begin
            buf_type_r <= T_NONE;
            state      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!bus.buf_ack) begin
            if (replay != 3'd4) begin
              buf_data_r <= hdr[replay[1:0]];
              buf_type_r <= ftype;
              replay     <= replay + 3'd1;
              state      <= S_SEND;
            end else if (last) begin
              state <= S_IDLE;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (accept) begin
            buf_data_r <= bus.rx_data;
            buf_type_r <= ftype;
            last       <= bus.rx_eof;
            state      <= S_SEND;
          end
        end
        S_DROP: begin
          if (accept && bus.rx_eof) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RX_DISPATCH_STATS_EN
  logic        arp_inc;
  logic        ip_inc;
  logic        drop_inc;
  logic [15:0] arp_r;
  logic [15:0] ip_r;
  logic [15:0] drop_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  // Counter events mirror the sequencer's classification and runt decisions
  always_comb begin
    arp_inc  = (state == S_CLASS) && is_arp;
    ip_inc   = (state == S_CLASS) && is_ip && !is_arp;
    drop_inc = ((state == S_CLASS) && !is_arp && !is_ip)
            || ((state == S_HDR) && accept
                && (bus.rx_sof || (bus.rx_eof && (hdr_cnt != 2'd3))))
            || ((state == S_IDLE) && accept && bus.rx_sof && bus.rx_eof);
  end

  // Saturating frame counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arp_r  <= '0;
      ip_r   <= '0;
      drop_r <= '0;
    end else begin
      if (arp_inc)  arp_r  <= sat_inc(arp_r);
      if (ip_inc)   ip_r   <= sat_inc(ip_r);
      if (drop_inc) drop_r <= sat_inc(drop_r);
    end
  end

  assign arp_cnt  = arp_r;
  assign ip_cnt   = ip_r;
  assign drop_cnt = drop_r;
`else
  assign arp_cnt  = '0;
  assign ip_cnt   = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_dispatch_ctrl.sv
// Bench for rx_dispatch_ctrl: drives frames on the MAC side, models the
// receive buffer's four-phase ack, and scoreboards every delivered word.
module tb_rx_dispatch_ctrl;

`ifdef RX_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int BUDGET = 300;

  logic        clk;
  logic        reset;
  logic        busy;
  logic [15:0] arp_cnt;
  logic [15:0] ip_cnt;
  logic [15:0] drop_cnt;

  rx_dispatch_ctrl_if bus ();

  rx_dispatch_ctrl #(
    .ETH_ARP(16'h0806),
    .ETH_IP (16'h0800)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .arp_cnt (arp_cnt),
    .ip_cnt  (ip_cnt),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_seen = 0;
  int          hs_viol = 0;
  int          ack_hold = 1;
  int          exp_arp = 0;
  int          exp_ip = 0;
  int          exp_drop = 0;
  logic [33:0] exp_q[$];
  logic [31:0] frm[$];

  logic [1:0]  prev_type = 2'd0;
  logic [31:0] prev_data = '0;
  int          ack_left = 0;

  function automatic logic [1:0] cls(input logic [31:0] w);
    if (w[31:16] == 16'h0806) return 2'd1;
    if (w[31:16] == 16'h0800) return 2'd2;
    return 2'd0;
  endfunction

  // Receive-buffer model and scoreboard: one pop per non-NONE phase
  always @(negedge clk) begin
    logic [33:0] e;
    if (reset) begin
      bus.buf_ack = 1'b0;
      ack_left    = 0;
      prev_type   = 2'd0;
    end else begin
      if (prev_type != 2'd0 && bus.buf_type != 2'd0 &&
          (bus.buf_type != prev_type || bus.buf_data != prev_data))
        hs_viol++;
      if (!bus.buf_ack) begin
        if (bus.buf_type != 2'd0) begin
          n_seen++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL word_unexpected: got type=%0d data=%h, required none", bus.buf_type, bus.buf_data);
          end else begin
            e = exp_q.pop_front();
            if ({bus.buf_type, bus.buf_data} !== e) begin
              n_bad++;
              $display("FAIL word_order: got type=%0d data=%h, required type=%0d data=%h",
                       bus.buf_type, bus.buf_data, e[33:32], e[31:0]);
            end
          end
          bus.buf_ack = 1'b1;
          ack_left    = ack_hold;
        end
      end else begin
        if (ack_left > 1) ack_left--;
        else if (bus.buf_type == 2'd0) bus.buf_ack = 1'b0;
      end
      prev_type = bus.buf_type;
      prev_data = bus.buf_data;
    end
  end

  task automatic push_word(input logic [31:0] d, input logic s, input logic e);
    int t = 0;
    @(negedge clk);
    bus.rx_data  = d;
    bus.rx_sof   = s;
    bus.rx_eof   = e;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (t >= BUDGET) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_accept_timeout: word %h not accepted, required acceptance within %0d cycles", d, BUDGET);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    bus.rx_eof   = 1'b0;
  endtask

  // Sends the first n_push words of frm; expectations queued as driven
  task automatic send_frame(input int n_push, input int gap);
    logic [1:0] t;
    t = (frm.size() >= 4) ? cls(frm[3]) : 2'd0;
    for (int i = 0; i < n_push; i++) begin
      if (t != 2'd0) exp_q.push_back({t, frm[i]});
      push_word(frm[i], i == 0, i == frm.size() - 1);
      repeat (gap) @(posedge clk);
    end
    if (n_push == frm.size()) begin
      if (t == 2'd1) exp_arp++;
      else if (t == 2'd2) exp_ip++;
      else exp_drop++;
    end
  endtask

  task automatic build_frame(input int n, input logic [31:0] w3);
    frm = {};
    for (int i = 0; i < n; i++) frm.push_back((i == 3) ? w3 : $urandom());
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < BUDGET && busy; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle: busy=%b, required 0", name, busy);
    end
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    bus.rx_eof   = 1'b0;
    bus.rx_data  = '0;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (bus.rx_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b, required 0", bus.rx_ready); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (bus.buf_type !== 2'd0) begin n_bad++; $display("FAIL reset_type: got %0d, required 0", bus.buf_type); end
    if (bus.buf_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h, required 0", bus.buf_data); end
    n_cmp++;
    if ({arp_cnt, ip_cnt, drop_cnt} !== 48'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %h/%h/%h, required 0", arp_cnt, ip_cnt, drop_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.rx_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b, required 1", bus.rx_ready); end
  endtask

  task automatic test_arp;
    ack_hold = 1;
    build_frame(6, 32'h0806_0001);
    send_frame(6, 0);
    wait_idle("arp");
    n_cmp += 3;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL arp_words: %0d words undelivered, required 0", exp_q.size()); end
    if (arp_cnt !== 16'(STATS ? exp_arp : 0)) begin n_bad++; $display("FAIL arp_cnt: got %0d, required %0d", arp_cnt, STATS ? exp_arp : 0); end
    if (bus.buf_type !== 2'd0) begin n_bad++; $display("FAIL arp_type_after: got %0d, required 0", bus.buf_type); end
  endtask

  task automatic test_ip_toggle;
    ack_hold = 1;
    build_frame(8, 32'h0800_4500);
    send_frame(8, 1);
    wait_idle("ip");
    n_cmp += 3;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL ip_words: %0d words undelivered, required 0", exp_q.size()); end
    if (ip_cnt !== 16'(STATS ? exp_ip : 0)) begin n_bad++; $display("FAIL ip_cnt: got %0d, required %0d", ip_cnt, STATS ? exp_ip : 0); end
    if (hs_viol != 0) begin n_bad++; $display("FAIL ip_none_phase: %0d type/data changes without NONE, required 0", hs_viol); end
  endtask

  task automatic test_drop;
    int seen0 = n_seen;
    build_frame(10, 32'h86DD_0000);
    send_frame(10, 0);
    wait_idle("drop");
    n_cmp += 2;
    if (n_seen != seen0) begin n_bad++; $display("FAIL drop_forwarded: %0d words forwarded, required 0", n_seen - seen0); end
    if (drop_cnt !== 16'(STATS ? exp_drop : 0)) begin n_bad++; $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, STATS ? exp_drop : 0); end
  endtask

  task automatic test_runt;
    int seen0 = n_seen;
    push_word(32'hDEAD_0001, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL stray_busy: got %b, required 0", busy); end
    if (drop_cnt !== 16'(STATS ? exp_drop : 0)) begin n_bad++; $display("FAIL stray_cnt: got %0d, required %0d", drop_cnt, STATS ? exp_drop : 0); end
    build_frame(3, 32'h0);
    send_frame(3, 0);
    wait_idle("runt");
    n_cmp += 3;
    if (drop_cnt !== 16'(STATS ? exp_drop : 0)) begin n_bad++; $display("FAIL runt_cnt: got %0d, required %0d", drop_cnt, STATS ? exp_drop : 0); end
    if (bus.buf_type !== 2'd0) begin n_bad++; $display("FAIL runt_type: got %0d, required 0", bus.buf_type); end
    if (n_seen != seen0) begin n_bad++; $display("FAIL runt_forwarded: %0d words, required 0", n_seen - seen0); end
    build_frame(5, 32'h0806_0002);
    send_frame(5, 0);
    wait_idle("runt_arp");
    n_cmp += 2;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL runt_arp_words: %0d undelivered, required 0", exp_q.size()); end
    if (arp_cnt !== 16'(STATS ? exp_arp : 0)) begin n_bad++; $display("FAIL runt_arp_cnt: got %0d, required %0d", arp_cnt, STATS ? exp_arp : 0); end
  endtask

  task automatic test_reset_midframe;
    int  seen0 = n_seen;
    bit  found = 1'b0;
    ack_hold = 3;
    build_frame(8, 32'h0806_0003);
    send_frame(5, 0);
    for (int i = 0; i < BUDGET && !found; i++) begin
      @(posedge clk);
      #2;
      if (n_seen == seen0 + 5 && bus.buf_type == 2'd0 && busy) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL rst_reach_release: word 5 release not reached, required within %0d cycles", BUDGET); end
    reset = 1'b1;
    #1;
    exp_arp = 0; exp_ip = 0; exp_drop = 0;
    n_cmp += 4;
    if (bus.buf_type !== 2'd0) begin n_bad++; $display("FAIL rst_type: got %0d, required 0", bus.buf_type); end
    if (bus.rx_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b, required 0", bus.rx_ready); end
    if ({arp_cnt, ip_cnt, drop_cnt} !== 48'd0) begin n_bad++; $display("FAIL rst_cnt: got %h/%h/%h, required 0", arp_cnt, ip_cnt, drop_cnt); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rst_words: %0d undelivered, required 0", exp_q.size()); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle_busy: got %b, required 0", busy); end
    if (bus.rx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_idle_ready: got %b, required 1", bus.rx_ready); end
  endtask

  task automatic test_back_to_back;
    ack_hold = 3;
    build_frame(5, 32'h0806_00AA);
    send_frame(5, 0);
    build_frame(6, 32'h0800_00BB);
    send_frame(6, 0);
    wait_idle("b2b");
    n_cmp += 4;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_words: %0d undelivered, required 0", exp_q.size()); end
    if (hs_viol != 0) begin n_bad++; $display("FAIL b2b_none_phase: %0d violations, required 0", hs_viol); end
    if (arp_cnt !== 16'(STATS ? exp_arp : 0)) begin n_bad++; $display("FAIL b2b_arp_cnt: got %0d, required %0d", arp_cnt, STATS ? exp_arp : 0); end
    if (ip_cnt !== 16'(STATS ? exp_ip : 0)) begin n_bad++; $display("FAIL b2b_ip_cnt: got %0d, required %0d", ip_cnt, STATS ? exp_ip : 0); end
  endtask

  initial begin
    test_reset();
    test_arp();
    test_ip_toggle();
    test_drop();
    test_runt();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
